// File: rtl/perf_trigger_pkg.sv
// rtl/perf_trigger_pkg.sv - shared types, constants and address helper for perf_trigger_master
package perf_trigger_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam logic [31:0] CLEAR_DATA = 32'h1;
  localparam int unsigned STOP_OFS   = 0;
  localparam int unsigned START_OFS  = 1;

  // Word address of a section's stop or start register
  function automatic int unsigned sect_addr(input int unsigned i, input logic is_start,
                                            input int unsigned stride);
    return i * stride + (is_start ? START_OFS : STOP_OFS);
  endfunction

endpackage

// File: rtl/perf_trigger_master_if.sv
// rtl/perf_trigger_master_if.sv - Avalon-MM write-only bus between trigger master and counter slave
interface perf_trigger_master_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/perf_rr_arbiter.sv
// rtl/perf_rr_arbiter.sv - combinational round-robin grant over section requests
module perf_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic             found;
  logic [PTR_W-1:0] j;

  // Scan from the pointer upward with wrap; first requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/perf_trigger_master.sv
// rtl/perf_trigger_master.sv - turns start/stop/clear event pulses into queued Avalon-MM writes
module perf_trigger_master
  import perf_trigger_pkg::*;
#(
  parameter int NUM_SECTIONS   = 4,
  parameter int ADDR_W         = 4,
  parameter int SECTION_STRIDE = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SECTIONS-1:0] start_req,
  input  logic [NUM_SECTIONS-1:0] stop_req,
  input  logic                    clear_req,
  perf_trigger_master_if.master   avm,
  output logic                    busy,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  localparam int PTR_W = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  state_e                  state_q, state_d;
  logic [NUM_SECTIONS-1:0] start_pend_q, start_pend_d;
  logic [NUM_SECTIONS-1:0] stop_pend_q, stop_pend_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    overflow_q, overflow_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [31:0]             data_q, data_d;

  logic [NUM_SECTIONS-1:0] gnt;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        rr_next;
  logic [NUM_SECTIONS-1:0] serve_start, serve_stop;
  logic                    serve_clr;
  logic                    any_pend;
  logic                    ovf_hit;

  perf_rr_arbiter #(
    .NUM_REQ (NUM_SECTIONS),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i (start_pend_q | stop_pend_q),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign any_pend = clr_pend_q | (|start_pend_q) | (|stop_pend_q);
  assign rr_next  = (gnt_idx == PTR_W'(NUM_SECTIONS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rr_d        = rr_q;
    serve_start = '0;
    serve_stop  = '0;
    serve_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_d = WRITE;
          if (clr_pend_q) begin
            serve_clr = 1'b1;
            addr_d    = '0;
            data_d    = CLEAR_DATA;
          end else if (|(gnt & stop_pend_q)) begin
            serve_stop = gnt;
            addr_d     = ADDR_W'(sect_addr(32'(gnt_idx), 1'b0, SECTION_STRIDE));
            data_d     = '0;
            rr_d       = rr_next;
          end else begin
            serve_start = gnt;
            addr_d      = ADDR_W'(sect_addr(32'(gnt_idx), 1'b1, SECTION_STRIDE));
            data_d      = '0;
            rr_d        = rr_next;
          end
        end
      end
      WRITE: begin
        if (!avm.avm_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pulse on the bit being served this cycle re-arms it rather than overflowing
    start_pend_d = (start_pend_q & ~serve_start) | start_req;
    stop_pend_d  = (stop_pend_q & ~serve_stop) | stop_req;
    clr_pend_d   = (clr_pend_q & ~serve_clr) | clear_req;

    ovf_hit = (|(start_req & start_pend_q & ~serve_start)) |
              (|(stop_req & stop_pend_q & ~serve_stop)) |
              (clear_req & clr_pend_q & ~serve_clr);

    overflow_d = ovf_hit ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_pend_q <= '0;
      stop_pend_q  <= '0;
      clr_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      rr_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      clr_pend_q   <= clr_pend_d;
      overflow_q   <= overflow_d;
      rr_q         <= rr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign avm.avm_write     = (state_q == WRITE);
  assign avm.avm_address   = addr_q;
  assign avm.avm_writedata = data_q;
  assign busy              = (state_q == WRITE) | any_pend;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_perf_trigger_master.sv
// tb/tb_perf_trigger_master.sv - directed vector bench for perf_trigger_master
module tb_perf_trigger_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] start_req;
  logic [3:0] stop_req;
  logic       clear_req;
  logic       busy;
  logic       overflow;
  logic       overflow_clr;

  int n_chk  = 0;
  int n_fail = 0;

  perf_trigger_master_if #(.ADDR_W(4)) avm ();

  perf_trigger_master #(
    .NUM_SECTIONS   (4),
    .ADDR_W         (4),
    .SECTION_STRIDE (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_req    (start_req),
    .stop_req     (stop_req),
    .clear_req    (clear_req),
    .avm          (avm.master),
    .busy         (busy),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  sp;
    logic        cl;
    logic [3:0]  a;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] st, input logic [3:0] sp, input logic cl);
    start_req = st;
    stop_req  = sp;
    clear_req = cl;
    tick();
    start_req = '0;
    stop_req  = '0;
    clear_req = 1'b0;
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (avm.avm_write) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic get_write(input string name, input logic [3:0] ea, input logic [31:0] ed);
    bit ok;
    wait_write(ok);
    chk({name, " seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({name, " addr"}, 32'(avm.avm_address), 32'(ea));
      chk({name, " data"}, avm.avm_writedata, ed);
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_exp [4];
    bit         ok;
    int         extra;

    rr_exp = '{4'd0, 4'd4, 4'd8, 4'd12};
    // stop i -> 4i, start i -> 4i+1, clear -> 0 with data 1
    tbl[0] = '{st: 4'b0001, sp: 4'b0000, cl: 1'b0, a: 4'd1,  d: 32'h0};
    tbl[1] = '{st: 4'b0010, sp: 4'b0000, cl: 1'b0, a: 4'd5,  d: 32'h0};
    tbl[2] = '{st: 4'b0100, sp: 4'b0000, cl: 1'b0, a: 4'd9,  d: 32'h0};
    tbl[3] = '{st: 4'b1000, sp: 4'b0000, cl: 1'b0, a: 4'd13, d: 32'h0};
    tbl[4] = '{st: 4'b0000, sp: 4'b0001, cl: 1'b0, a: 4'd0,  d: 32'h0};
    tbl[5] = '{st: 4'b0000, sp: 4'b0010, cl: 1'b0, a: 4'd4,  d: 32'h0};
    tbl[6] = '{st: 4'b0000, sp: 4'b0100, cl: 1'b0, a: 4'd8,  d: 32'h0};
    tbl[7] = '{st: 4'b0000, sp: 4'b1000, cl: 1'b0, a: 4'd12, d: 32'h0};
    tbl[8] = '{st: 4'b0000, sp: 4'b0000, cl: 1'b1, a: 4'd0,  d: 32'h1};

    start_req           = '0;
    stop_req            = '0;
    clear_req           = 1'b0;
    overflow_clr        = 1'b0;
    avm.avm_waitrequest = 1'b0;
    reset_n             = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    chk("reset write", 32'(avm.avm_write), 32'd0);
    chk("reset addr", 32'(avm.avm_address), 32'd0);
    chk("reset data", avm.avm_writedata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);

    // Single start: write appears exactly two cycles after the pulse, for one cycle
    pulse(4'b0001, 4'b0000, 1'b0);
    chk("single t+1 write", 32'(avm.avm_write), 32'd0);
    chk("single t+1 busy", 32'(busy), 32'd1);
    tick();
    chk("single t+2 write", 32'(avm.avm_write), 32'd1);
    chk("single addr", 32'(avm.avm_address), 32'd1);
    chk("single data", avm.avm_writedata, 32'd0);
    tick();
    chk("single t+3 write", 32'(avm.avm_write), 32'd0);
    chk("single busy after", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].st, tbl[i].sp, tbl[i].cl);
      get_write($sformatf("vec%0d", i), tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
    end

    // Same-cycle clear plus start/stop on section 1
    do_reset();
    pulse(4'b0010, 4'b0010, 1'b1);
    get_write("order clear", 4'd0, 32'h1);
    get_write("order stop1", 4'd4, 32'h0);
    get_write("order start1", 4'd5, 32'h0);
    chk("order busy", 32'(busy), 32'd0);

    // Backpressure: five stalled cycles then acceptance
    avm.avm_waitrequest = 1'b1;
    pulse(4'b0100, 4'b0000, 1'b0);
    wait_write(ok);
    chk("bp seen", 32'(ok), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp cyc%0d write", k), 32'(avm.avm_write), 32'd1);
      chk($sformatf("bp cyc%0d addr", k), 32'(avm.avm_address), 32'd9);
      if (k == 5) avm.avm_waitrequest = 1'b0;
      tick();
    end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (avm.avm_write) extra++;
      tick();
    end
    chk("bp single accept", 32'(extra), 32'd0);

    // Round-robin over all sections, twice
    do_reset();
    for (int b = 0; b < 2; b++) begin
      pulse(4'b0000, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) get_write($sformatf("rr b%0d w%0d", b, i), rr_exp[i], 32'h0);
    end

    // Overflow: stop3 pulsed twice while another write is stalled
    do_reset();
    avm.avm_waitrequest = 1'b1;
    pulse(4'b0001, 4'b0000, 1'b0);
    wait_write(ok);
    pulse(4'b0000, 4'b1000, 1'b0);
    chk("ovf first", 32'(overflow), 32'd0);
    pulse(4'b0000, 4'b1000, 1'b0);
    chk("ovf second", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    pulse(4'b0000, 4'b1000, 1'b0);
    overflow_clr = 1'b0;
    chk("ovf set wins", 32'(overflow), 32'd1);
    avm.avm_waitrequest = 1'b0;
    get_write("ovf start0", 4'd1, 32'h0);
    get_write("ovf stop3", 4'd12, 32'h0);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (avm.avm_write) extra++;
      tick();
    end
    chk("ovf single stop3", 32'(extra), 32'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf cleared", 32'(overflow), 32'd0);

    // Asynchronous reset in the middle of a stalled write
    avm.avm_waitrequest = 1'b1;
    pulse(4'b0000, 4'b0100, 1'b0);
    wait_write(ok);
    pulse(4'b0001, 4'b0000, 1'b0);
    pulse(4'b0001, 4'b0000, 1'b0);
    chk("rst pre write", 32'(avm.avm_write), 32'd1);
    chk("rst pre overflow", 32'(overflow), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst async write", 32'(avm.avm_write), 32'd0);
    chk("rst async busy", 32'(busy), 32'd0);
    tick();
    reset_n             = 1'b1;
    avm.avm_waitrequest = 1'b0;
    tick();
    chk("rst post write", 32'(avm.avm_write), 32'd0);
    chk("rst post busy", 32'(busy), 32'd0);
    chk("rst post overflow", 32'(overflow), 32'd0);
    chk("rst post addr", 32'(avm.avm_address), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
